// File: rtl/frame_page_pkg.sv
// ---------------------------------------------------------------------------
// frame_page_pkg : shared types and helpers for the frame page arbiter | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frame_page_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } page_state_t;

    localparam int STAT_W = 16;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_page_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// page_index_fifo : ordered queue of ready page indices, head = oldest | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module page_index_fifo #(
    parameter int DEPTH     = 2,
    parameter int PAGE_W    = 2,
    parameter int NUM_PAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 pop_i,
    input  logic                 push_i,
    input  logic [PAGE_W-1:0]    push_idx_i,
    output logic [PAGE_W-1:0]    head_o,
    output logic [PAGE_W-1:0]    tail_o,
    output logic [PAGE_W:0]      count_o,
    output logic [NUM_PAGES-1:0] mask_o
);
    localparam int CNT_W = PAGE_W + 1;

    logic [PAGE_W-1:0] entry_q [DEPTH];
    logic [PAGE_W-1:0] entry_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow;

    always_comb begin
        head_o = entry_q[0];
        tail_o = entry_q[0];
        mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                tail_o             = entry_q[i];
                mask_o[entry_q[i]] = 1'b1;
            end
        end
    end

    // Applied in order flush -> pop -> push so one cycle can retire and refill.
    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        overflow = 1'b0;
        if (flush_i && count_q != '0) begin
            entry_d[0] = tail_o;
            count_d    = CNT_W'(1);
        end
        if (pop_i && count_d != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_d[i] = entry_d[i+1];
            end
            count_d = count_d - CNT_W'(1);
        end
        if (push_i) begin
            if (count_d == CNT_W'(DEPTH)) begin
                overflow = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == count_d) entry_d[i] = push_idx_i;
                end
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

`default_nettype wire

// File: rtl/frame_page_arbiter.sv
// ---------------------------------------------------------------------------
// frame_page_arbiter : writer/reader frame page manager; stats via FRAME_PAGE_STATS_EN
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_page_arbiter
    import frame_page_pkg::*;
#(
    parameter int NUM_PAGES   = 3,
    parameter int PAGE_W      = $clog2(NUM_PAGES),
    parameter int LATEST_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              end_of_write,
    input  logic              end_of_read,
    output logic [PAGE_W-1:0] write_page,
    output logic              write_enable,
    output logic [PAGE_W-1:0] read_page,
    output logic              read_valid,
    output logic [PAGE_W:0]   ready_count,
    output logic [15:0]       frames_dropped,
    output logic [15:0]       frames_repeated,
    output logic [15:0]       write_stalls
);
    // A stalled writer's last page stays queued, so the queue can hold N-1.
    localparam int DEPTH = NUM_PAGES - 1;

    logic [PAGE_W-1:0]    read_q, read_d, write_q, write_d;
    logic                 valid_q, valid_d, we_q, we_d;
    logic                 q_flush, q_pop, q_push;
    logic [PAGE_W-1:0]    q_head, q_tail;
    logic [PAGE_W:0]      q_count;
    logic [NUM_PAGES-1:0] q_mask, free_pages;
    logic                 nonempty, do_read, accept, any_free;
    logic [PAGE_W-1:0]    lowest_free;

    function automatic logic [NUM_PAGES-1:0] onehot(input logic [PAGE_W-1:0] idx);
        logic [NUM_PAGES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    page_index_fifo #(
        .DEPTH     (DEPTH),
        .PAGE_W    (PAGE_W),
        .NUM_PAGES (NUM_PAGES)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush_i    (q_flush),
        .pop_i      (q_pop),
        .push_i     (q_push),
        .push_idx_i (write_q),
        .head_o     (q_head),
        .tail_o     (q_tail),
        .count_o    (q_count),
        .mask_o     (q_mask)
    );

    always_comb begin
        read_d     = read_q;
        valid_d    = valid_q;
        write_d    = write_q;
        we_d       = we_q;
        q_flush    = 1'b0;
        q_pop      = 1'b0;
        q_push     = 1'b0;
        nonempty   = (q_count != '0);
        do_read    = end_of_read && nonempty;
        accept     = end_of_write && we_q;
        free_pages = ~(onehot(read_q) | q_mask | (we_q ? onehot(write_q) : '0));

        // Read first: pages it frees are visible to this cycle's allocation.
        if (do_read) begin
            free_pages[read_q] = 1'b1;
            valid_d            = 1'b1;
            q_pop              = 1'b1;
            if (LATEST_MODE != 0) begin
                read_d     = q_tail;
                q_flush    = 1'b1;
                free_pages = free_pages | (q_mask & ~onehot(q_tail));
            end else begin
                read_d = q_head;
            end
        end

        any_free    = |free_pages;
        lowest_free = PAGE_W'(lowest_set(16'(free_pages)));

        if (accept) begin
            q_push = 1'b1;
            if (any_free) begin
                write_d = lowest_free;
            end else if (LATEST_MODE != 0) begin
                write_d = q_head;
                q_pop   = 1'b1;
            end else begin
                we_d = 1'b0;
            end
        end else if (!we_q && any_free) begin
            write_d = lowest_free;
            we_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q  <= '0;
            valid_q <= 1'b0;
            write_q <= PAGE_W'(1);
            we_q    <= 1'b1;
        end else begin
            read_q  <= read_d;
            valid_q <= valid_d;
            write_q <= write_d;
            we_q    <= we_d;
        end
    end

    assign read_page    = read_q;
    assign read_valid   = valid_q;
    assign write_page   = write_q;
    assign write_enable = we_q;
    assign ready_count  = q_count;

`ifdef FRAME_PAGE_STATS_EN
    logic [STAT_W-1:0] dropped_q, repeated_q, stalls_q, drop_amt;

    always_comb begin
        drop_amt = '0;
        if (LATEST_MODE != 0) begin
            if (do_read) drop_amt = STAT_W'(q_count) - STAT_W'(1);
            else if (accept && !any_free) drop_amt = STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dropped_q  <= '0;
            repeated_q <= '0;
            stalls_q   <= '0;
        end else begin
            dropped_q <= sat_add(dropped_q, drop_amt);
            if (end_of_read && !nonempty && valid_q)
                repeated_q <= sat_add(repeated_q, STAT_W'(1));
            if (end_of_write && !we_q)
                stalls_q <= sat_add(stalls_q, STAT_W'(1));
        end
    end

    assign frames_dropped  = dropped_q;
    assign frames_repeated = repeated_q;
    assign write_stalls    = stalls_q;
`else
    assign frames_dropped  = 16'd0;
    assign frames_repeated = 16'd0;
    assign write_stalls    = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_page_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_page_arbiter : directed checks on three arbiter configurations | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_frame_page_arbiter;

`ifdef FRAME_PAGE_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic ew_a, er_a, ew_b, er_b, ew_c, er_c;

    // a: N=3 latest, b: N=3 fifo, c: N=5 fifo
    logic [1:0]  wp_a, rp_a, wp_b, rp_b;
    logic [2:0]  rc_a, rc_b, wp_c, rp_c;
    logic [3:0]  rc_c;
    logic        we_a, rv_a, we_b, rv_b, we_c, rv_c;
    logic [15:0] fd_a, fr_a, ws_a, fd_b, fr_b, ws_b, fd_c, fr_c, ws_c;

    frame_page_arbiter #(.NUM_PAGES(3), .LATEST_MODE(1)) u_a (
        .clk(clk), .reset(reset), .end_of_write(ew_a), .end_of_read(er_a),
        .write_page(wp_a), .write_enable(we_a), .read_page(rp_a), .read_valid(rv_a),
        .ready_count(rc_a), .frames_dropped(fd_a), .frames_repeated(fr_a),
        .write_stalls(ws_a));

    frame_page_arbiter #(.NUM_PAGES(3), .LATEST_MODE(0)) u_b (
        .clk(clk), .reset(reset), .end_of_write(ew_b), .end_of_read(er_b),
        .write_page(wp_b), .write_enable(we_b), .read_page(rp_b), .read_valid(rv_b),
        .ready_count(rc_b), .frames_dropped(fd_b), .frames_repeated(fr_b),
        .write_stalls(ws_b));

    frame_page_arbiter #(.NUM_PAGES(5), .LATEST_MODE(0)) u_c (
        .clk(clk), .reset(reset), .end_of_write(ew_c), .end_of_read(er_c),
        .write_page(wp_c), .write_enable(we_c), .read_page(rp_c), .read_valid(rv_c),
        .ready_count(rc_c), .frames_dropped(fd_c), .frames_repeated(fr_c),
        .write_stalls(ws_c));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_pulses();
        {ew_a, er_a, ew_b, er_b, ew_c, er_c} = '0;
    endtask

    // Each step drives a pulse at a negedge and returns at the next negedge.
    task automatic step_a(input logic ew, input logic er);
        ew_a = ew; er_a = er;
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic step_b(input logic ew, input logic er);
        ew_b = ew; er_b = er;
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic step_c(input logic ew, input logic er);
        ew_c = ew; er_c = er;
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_pulses();
        do_reset();

        check("rst_rp", rp_a, 0);
        check("rst_rv", rv_a, 0);
        check("rst_wp", wp_a, 1);
        check("rst_we", we_a, 1);
        check("rst_rc", rc_a, 0);
        check("rst_fd", fd_a, 0);
        check("rst_c_wp", wp_c, 1);

        // Latest mode: second write overwrites the oldest ready page
        step_a(1, 0);
        check("l_w1_wp", wp_a, 2);
        check("l_w1_rc", rc_a, 1);
        step_a(1, 0);
        check("l_w2_wp", wp_a, 1);
        check("l_w2_rc", rc_a, 1);
        check("l_w2_we", we_a, 1);
        check("l_w2_fd", fd_a, S * 1);
        step_a(0, 1);
        check("l_r1_rp", rp_a, 2);
        check("l_r1_rv", rv_a, 1);
        check("l_r1_rc", rc_a, 0);
        check("l_r1_fd", fd_a, S * 1);
        step_a(0, 1);
        check("l_rep_rp", rp_a, 2);
        check("l_rep_fr", fr_a, S * 1);

        // FIFO mode: fill, stall, recover on read
        step_b(1, 0);
        check("f_w1_wp", wp_b, 2);
        step_b(1, 0);
        check("f_w2_we", we_b, 0);
        check("f_w2_rc", rc_b, 2);
        check("f_w2_wp", wp_b, 2);
        step_b(1, 0);
        check("f_w3_ws", ws_b, S * 1);
        check("f_w3_rc", rc_b, 2);
        step_b(0, 1);
        check("f_r_rp", rp_b, 1);
        check("f_r_rv", rv_b, 1);
        check("f_r_wp", wp_b, 0);
        check("f_r_we", we_b, 1);
        check("f_r_rc", rc_b, 1);
        check("f_r_fd", fd_b, 0);

        // Simultaneous read and write in latest mode
        do_reset();
        step_a(1, 0);
        check("s_w1_wp", wp_a, 2);
        step_a(1, 1);
        check("s_rp", rp_a, 1);
        check("s_wp", wp_a, 0);
        check("s_rc", rc_a, 1);
        check("s_fd", fd_a, 0);
        step_a(0, 1);
        check("s_r2_rp", rp_a, 2);
        check("s_r2_rc", rc_a, 0);
        check("s_r2_fr", fr_a, 0);

        // N=5 FIFO fill, then asynchronous reset with a pulse in flight
        step_c(1, 0);
        step_c(1, 0);
        step_c(1, 0);
        check("c_w3_wp", wp_c, 4);
        check("c_w3_rc", rc_c, 3);
        check("c_w3_we", we_c, 1);
        step_c(1, 0);
        check("c_w4_we", we_c, 0);
        check("c_w4_rc", rc_c, 4);
        ew_c = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("c_ar_wp", wp_c, 1);
        check("c_ar_we", we_c, 1);
        check("c_ar_rc", rc_c, 0);
        check("c_ar_rp", rp_c, 0);
        check("c_ar_rv", rv_c, 0);
        @(negedge clk);
        clear_pulses();
        reset = 1'b1;
        @(negedge clk);
        check("c_post_wp", wp_c, 1);
        check("c_post_rc", rc_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
